lc3_datapath_param: RTL and testbench

Parametrised, fully synthesizable successor to the processor datapath. It holds PC, IR, MAR and MDR, an 8-entry register file, the ALU, the address adder, NZP condition codes and the BEN latch. All of these drive a single internal muxed bus in place of tri-state buffers. It sits between the ISDU control FSM, which drives every LD_/Gate/MUX input, and the SRAM interface.

---
 rtl/lc3_datapath_param.sv | 189 ++++++++++++++++++
 tb/tb_lc3_datapath_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_datapath_param.sv
// LC-3 style datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address adder,
// NZP/BEN, with a priority-muxed internal bus and a sticky multi-driver flag.
module lc3_datapath_param #(
  parameter int              WIDTH    = 16,
  parameter longint unsigned RESET_PC = 64'h0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic             MARMUX,
  input  logic [1:0]       ALUK,
  input  logic             MIO_EN,
  input  logic [WIDTH-1:0] Data_from_mem,
  output logic [WIDTH-1:0] ADDR,
  output logic [WIDTH-1:0] Data_to_mem,
  output logic [WIDTH-1:0] IR_val,
  output logic [WIDTH-1:0] PC_val,
  output logic [WIDTH-1:0] Bus_val,
  output logic [2:0]       NZP,
  output logic             BEN,
  output logic             bus_err
);

  if (WIDTH < 16) begin : g_width_check
    $error("lc3_datapath_param: WIDTH must be at least 16");
  end

  localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(RESET_PC);

  // Sign extension from the field MSB to the full datapath width
  function automatic logic signed [WIDTH-1:0] sext5(input logic signed [4:0] f);
    return WIDTH'(f);
  endfunction

  function automatic logic signed [WIDTH-1:0] sext6(input logic signed [5:0] f);
    return WIDTH'(f);
  endfunction

  function automatic logic signed [WIDTH-1:0] sext9(input logic signed [8:0] f);
    return WIDTH'(f);
  endfunction

  function automatic logic signed [WIDTH-1:0] sext11(input logic signed [10:0] f);
    return WIDTH'(f);
  endfunction

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mar_q;
  logic [WIDTH-1:0] mdr_q;
  logic [2:0]       nzp_q;
  logic             ben_q;
  logic             bus_err_q;
  logic [WIDTH-1:0] rf_q [8];

  logic [15:0]      ir;
  logic [2:0]       dr_sel;
  logic [2:0]       sr1_sel;
  logic [2:0]       sr2_sel;
  logic [WIDTH-1:0] sr1_val;
  logic [WIDTH-1:0] sr2_val;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] addr2;
  logic [WIDTH-1:0] addr_sum;
  logic [WIDTH-1:0] marmux_out;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] mdr_next;
  logic [2:0]       cc_next;
  logic             ben_next;
  logic             bus_zero;
  logic             multi_gate;

  // Instruction fields always come from the low 16 bits of IR
  assign ir      = ir_q[15:0];
  assign dr_sel  = DRMUX  ? 3'd7      : ir[11:9];
  assign sr1_sel = SR1MUX ? ir[11:9]  : ir[8:6];
  assign sr2_sel = ir[2:0];

  // Reads see the pre-edge contents, so a same-cycle write returns the old value
  assign sr1_val = rf_q[sr1_sel];
  assign sr2_val = rf_q[sr2_sel];

  always_comb begin
    alu_b   = SR2MUX ? sext5(ir[4:0]) : sr2_val;
    alu_out = sr1_val;
    unique case (ALUK)
      2'b00:   alu_out = sr1_val + alu_b;
      2'b01:   alu_out = sr1_val & alu_b;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  always_comb begin
    addr1 = ADDR1MUX ? sr1_val : pc_q;
    addr2 = '0;
    unique case (ADDR2MUX)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = sext6(ir[5:0]);
      2'b10:   addr2 = sext9(ir[8:0]);
      default: addr2 = sext11(ir[10:0]);
    endcase
    addr_sum   = addr1 + addr2;
    marmux_out = MARMUX ? WIDTH'(ir[7:0]) : addr_sum;
  end

  // Bus source priority replaces the tri-state gates of the original design
  always_comb begin
    bus = '0;
    if (GatePC)
      bus = pc_q;
    else if (GateMDR)
      bus = mdr_q;
    else if (GateALU)
      bus = alu_out;
    else if (GateMARMUX)
      bus = marmux_out;
  end

  assign multi_gate = (GatePC  & GateMDR) | (GatePC  & GateALU) | (GatePC  & GateMARMUX) |
                      (GateMDR & GateALU) | (GateMDR & GateMARMUX) | (GateALU & GateMARMUX);

  always_comb begin
    pc_next = pc_q;
    unique case (PCMUX)
      2'b00:   pc_next = pc_q + WIDTH'(1);
      2'b01:   pc_next = bus;
      2'b10:   pc_next = addr_sum;
      default: pc_next = pc_q;
    endcase
  end

  assign mdr_next = MIO_EN ? Data_from_mem : bus;
  assign bus_zero = (bus == '0);
  assign cc_next  = {bus[WIDTH-1], bus_zero, ~bus[WIDTH-1] & ~bus_zero};
  // Built from pre-edge IR/NZP so concurrent LD_IR/LD_CC cannot leak in
  assign ben_next = (ir[11] & nzp_q[2]) | (ir[10] & nzp_q[1]) | (ir[9] & nzp_q[0]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q      <= PC_INIT;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      nzp_q     <= 3'b010;
      ben_q     <= 1'b0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (LD_PC)      pc_q      <= pc_next;
      if (LD_IR)      ir_q      <= bus;
      if (LD_MAR)     mar_q     <= bus;
      if (LD_MDR)     mdr_q     <= mdr_next;
      if (LD_CC)      nzp_q     <= cc_next;
      if (LD_BEN)     ben_q     <= ben_next;
      if (multi_gate) bus_err_q <= 1'b1;
      if (LD_REG)     rf_q[dr_sel] <= bus;
    end
  end

  assign ADDR        = mar_q;
  assign Data_to_mem = mdr_q;
  assign IR_val      = ir_q;
  assign PC_val      = pc_q;
  assign Bus_val     = bus;
  assign NZP         = nzp_q;
  assign BEN         = ben_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_lc3_datapath_param.sv
// Directed bench for lc3_datapath_param at WIDTH=16, RESET_PC=0x3000.
module tb_lc3_datapath_param;

  logic        Clk;
  logic        Reset;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0]  ADDR2MUX;
  logic        MARMUX;
  logic [1:0]  ALUK;
  logic        MIO_EN;
  logic [15:0] Data_from_mem;
  logic [15:0] ADDR, Data_to_mem, IR_val, PC_val, Bus_val;
  logic [2:0]  NZP;
  logic        BEN;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  lc3_datapath_param #(.WIDTH(16), .RESET_PC(64'h3000)) dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
    .MIO_EN(MIO_EN), .Data_from_mem(Data_from_mem),
    .ADDR(ADDR), .Data_to_mem(Data_to_mem), .IR_val(IR_val), .PC_val(PC_val),
    .Bus_val(Bus_val), .NZP(NZP), .BEN(BEN), .bus_err(bus_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0; LD_PC = 0;
    GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
    PCMUX = 2'b00; DRMUX = 0; SR1MUX = 0; SR2MUX = 0; ADDR1MUX = 0;
    ADDR2MUX = 2'b00; MARMUX = 0; ALUK = 2'b00; MIO_EN = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    clr();
  endtask

  task automatic mem_to_mdr(input logic [15:0] d);
    MIO_EN = 1; Data_from_mem = d; LD_MDR = 1;
    tick();
  endtask

  initial begin
    clr();
    Data_from_mem = 16'h0000;
    Reset = 1;
    #1;
    check("rst_pc_async", PC_val, 16'h3000);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_pc", PC_val, 16'h3000);
    check("rst_nzp", 16'(NZP), 16'h0002);
    check("rst_ir", IR_val, 16'h0000);
    check("rst_mar", ADDR, 16'h0000);
    check("rst_mdr", Data_to_mem, 16'h0000);
    check("rst_buserr", 16'(bus_err), 16'h0000);
    check("rst_ben", 16'(BEN), 16'h0000);
    check("bus_idle", Bus_val, 16'h0000);
    Reset = 0;

    // Fetch
    GatePC = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 2'b00;
    #1 check("fetch_bus", Bus_val, 16'h3000);
    tick();
    check("fetch_mar", ADDR, 16'h3000);
    check("fetch_pc", PC_val, 16'h3001);
    mem_to_mdr(16'h1261);
    check("fetch_mdr", Data_to_mem, 16'h1261);
    GateMDR = 1; LD_IR = 1;
    #1 check("ir_bus", Bus_val, 16'h1261);
    tick();
    check("fetch_ir", IR_val, 16'h1261);

    // R1 <= 0xFFFF through the bus, CC goes negative
    mem_to_mdr(16'hFFFF);
    GateMDR = 1; LD_REG = 1; LD_CC = 1; DRMUX = 0;
    tick();
    check("cc_neg", 16'(NZP), 16'h0004);

    // ADD R1,R1,#1 twice
    SR1MUX = 0; SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
    #1 check("add1_bus", Bus_val, 16'h0000);
    tick();
    check("add1_cc", 16'(NZP), 16'h0002);
    SR1MUX = 0; SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
    #1 check("add2_bus", Bus_val, 16'h0001);
    tick();
    check("add2_cc", 16'(NZP), 16'h0001);

    // Same-cycle write/read of R1
    SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1;
    #1 check("wr_rd_old", Bus_val, 16'h0002);
    tick();
    ALUK = 2'b11; GateALU = 1;
    #1 check("wr_rd_new", Bus_val, 16'h0002);
    ALUK = 2'b01; SR2MUX = 1;
    #1 check("alu_and", Bus_val, 16'h0000);
    ALUK = 2'b10;
    #1 check("alu_not", Bus_val, 16'hFFFD);
    clr();

    // Branch setup: NZP=Z, IR=BRz +2
    LD_CC = 1;
    tick();
    check("cc_zero_idle", 16'(NZP), 16'h0002);
    mem_to_mdr(16'h0402);
    GateMDR = 1; LD_IR = 1;
    tick();
    LD_BEN = 1;
    tick();
    check("ben_set", 16'(BEN), 16'h0001);
    LD_BEN = 1; GatePC = 1; LD_CC = 1;
    tick();
    check("ben_old_cc", 16'(BEN), 16'h0001);
    check("cc_pos_pc", 16'(NZP), 16'h0001);
    LD_BEN = 1;
    tick();
    check("ben_clear", 16'(BEN), 16'h0000);
    ADDR1MUX = 0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1;
    tick();
    check("br_pc", PC_val, 16'h3003);

    // PC back to 0x3001, then branch by -1
    mem_to_mdr(16'h3001);
    GateMDR = 1; PCMUX = 2'b01; LD_PC = 1;
    tick();
    check("pc_from_bus", PC_val, 16'h3001);
    mem_to_mdr(16'h0FFF);
    GateMDR = 1; LD_IR = 1;
    tick();
    ADDR1MUX = 0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1;
    tick();
    check("br_wrap", PC_val, 16'h3000);

    // Address adder / MARMUX paths, IR=0x0FFF, PC=0x3000
    GateMARMUX = 1; MARMUX = 0; ADDR1MUX = 0; ADDR2MUX = 2'b01;
    #1 check("adr_off6", Bus_val, 16'h2FFF);
    ADDR2MUX = 2'b11;
    #1 check("adr_off11", Bus_val, 16'h2FFF);
    ADDR2MUX = 2'b00;
    #1 check("adr_zero", Bus_val, 16'h3000);
    MARMUX = 1; DRMUX = 1; LD_REG = 1; LD_MAR = 1;
    #1 check("marmux_zext", Bus_val, 16'h00FF);
    tick();
    check("mar_zext", ADDR, 16'h00FF);
    GateALU = 1; SR1MUX = 1; ALUK = 2'b11;
    #1 check("r7_pass", Bus_val, 16'h00FF);
    SR2MUX = 0; ALUK = 2'b00;
    #1 check("r7_add_reg", Bus_val, 16'h01FE);
    clr();
    GateMARMUX = 1; MARMUX = 0; ADDR1MUX = 1; SR1MUX = 1; ADDR2MUX = 2'b01;
    #1 check("adr_base_reg", Bus_val, 16'h00FE);
    clr();

    // PC hold and self-reload
    PCMUX = 2'b11; LD_PC = 1;
    tick();
    check("pc_hold", PC_val, 16'h3000);
    GatePC = 1; PCMUX = 2'b01; LD_PC = 1;
    tick();
    check("pc_self", PC_val, 16'h3000);

    // PC+1 wrap
    mem_to_mdr(16'hFFFF);
    GateMDR = 1; PCMUX = 2'b01; LD_PC = 1;
    tick();
    PCMUX = 2'b00; LD_PC = 1;
    tick();
    check("pc_inc_wrap", PC_val, 16'h0000);

    // Bus conflict
    GatePC = 1; GateMDR = 1;
    #1 check("conflict_bus", Bus_val, 16'h0000);
    check("conflict_pre", 16'(bus_err), 16'h0000);
    tick();
    check("conflict_err", 16'(bus_err), 16'h0001);
    tick();
    check("conflict_sticky", 16'(bus_err), 16'h0001);

    // Asynchronous reset mid-cycle
    #2 Reset = 1;
    #1;
    check("arst_pc", PC_val, 16'h3000);
    check("arst_err", 16'(bus_err), 16'h0000);
    check("arst_ir", IR_val, 16'h0000);
    check("arst_mar", ADDR, 16'h0000);
    check("arst_mdr", Data_to_mem, 16'h0000);
    check("arst_nzp", 16'(NZP), 16'h0002);
    Reset = 0;
    tick();
    check("post_rst_err", 16'(bus_err), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
